num_joiner: RTL and testbench
=============================

Name: num_joiner

Overview:
- Inverse of the tens/units splitter: assembles a two-digit decimal number from a stream of single BCD digits (tens first, then units) into an 8-bit binary value.
- Sits between the keypad/digit source and the 8-bit number register that feeds the splitter and 7-segment path.
- Sequential entry FSM with a one-cycle commit strobe, a single-digit commit, an inter-digit timeout and error flagging.

Parameters:
- WIDTH, 8, width of the assembled binary output; must be >= 7.
- TIMEOUT_CYCLES, 1000000, max clk cycles to wait for the units digit after the tens digit; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digito  input  4  BCD digit, sampled only when digito_valid=1.
- digito_valid  input  1  one-cycle strobe, digit present.
- enter  input  1  one-cycle strobe, commit the pending single digit.
- clear  input  1  synchronous abort, discards the partial entry.
- numero  output  WIDTH  last committed binary value, held between commits.
- numero_valid  output  1  one-cycle pulse, numero just updated.
- busy  output  1  high while a tens digit is held (WAIT_UNITS).
- error  output  1  one-cycle pulse on an invalid digit or a timeout.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, numero=0, numero_valid=0, busy=0, error=0, tens register=0, timeout counter=0.
- States: IDLE, WAIT_UNITS. busy=1 exactly when state=WAIT_UNITS (registered).
- Input priority each cycle: clear > digito_valid > enter > timeout.
- clear=1: go to IDLE, drop the held tens, zero the counter. numero is unchanged. No numero_valid, no error.
- Invalid digit (digito_valid=1 with digito>9), any state:
  - error pulses the next cycle; state goes to IDLE and the held tens is dropped.
  - numero is unchanged.
- IDLE:
  - Valid digit: store it as tens, go to WAIT_UNITS, clear the counter.
  - enter is ignored. No outputs change.
- WAIT_UNITS, valid digit u:
  - Next edge: numero = tens*10 + u, numero_valid=1, state goes to IDLE.
  - Latency is one cycle from the digit strobe to numero/numero_valid.
- WAIT_UNITS, enter=1 with no digit: next edge numero = tens (zero-extended), numero_valid=1, state goes to IDLE.
- WAIT_UNITS, digito_valid and enter in the same cycle: the digit wins and enter is ignored.
- Timeout, only when TIMEOUT_CYCLES>0:
  - The counter increments on each WAIT_UNITS cycle that has no accepted input.
  - When it reaches TIMEOUT_CYCLES: error pulses, state goes to IDLE, tens is dropped, numero is unchanged.
  - The counter never wraps; its width is ceil(log2(TIMEOUT_CYCLES+1)).
- Arithmetic:
  - tens*10 is computed as (tens<<3)+(tens<<1) in 7 bits; maximum result 99, so no overflow.
  - The result is zero-extended to WIDTH.
- numero_valid and error are never high in the same cycle. Each is high for exactly one cycle per event.
- Back-to-back digit strobes on consecutive cycles are all accepted. Example: 4,5,6,7 yields numero=45 then numero=67.
- Reset mid-entry: the held digit is lost and outputs return to reset values immediately.
- Round-trip rule: any 0..99 value fed through num_joiner and then the splitter reproduces the original two digits.

Test Plan:
- Reset then digito=4 strobe, digito=5 strobe -> one cycle after the 5: numero=45, numero_valid pulse, busy 1 then 0, error=0.
- digito=7 strobe, then enter two cycles later -> numero=7, numero_valid pulse. enter strobed while IDLE -> no change.
- digito=3, then digito=12 (invalid) -> error pulse, numero holds its prior value, busy=0. Next digits 9,9 -> numero=99.
- TIMEOUT_CYCLES=5: digito=2, then idle for 5 cycles -> error pulse on the timeout, numero unchanged. digito=2 with units after 3 cycles -> numero=2*10+units, no error.
- digito=6 then clear in the same cycle as digito=1 -> no commit, busy=0, numero unchanged. digito=1 with enter in the same cycle while in WAIT_UNITS -> digit wins, numero=61.
- Sweep all 100 tens/units pairs back-to-back, then rst_n pulse mid-entry -> each numero equals 10*t+u with one numero_valid per pair. After reset: numero=0, busy=0.

Source files
------------

// File: rtl/num_joiner.sv
// rtl/num_joiner.sv - assembles a two-digit BCD entry (tens then units) into a binary value
module num_joiner #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       digito,
  input  logic             digito_valid,
  input  logic             enter,
  input  logic             clear,
  output logic [WIDTH-1:0] numero,
  output logic             numero_valid,
  output logic             busy,
  output logic             error
);

  // Counter wide enough to hold TIMEOUT_CYCLES; kept at one bit when the timeout is disabled.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    IDLE,
    WAIT_UNITS
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       tens_q, tens_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] numero_q, numero_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [6:0]       tens_ext;
  logic [6:0]       tens_x10;
  logic [6:0]       sum;
  logic             digit_ok;

  // tens*10 as shift-add; 9*10+9 = 99 fits in 7 bits so nothing overflows.
  assign tens_ext = {3'b000, tens_q};
  assign tens_x10 = (tens_ext << 3) + (tens_ext << 1);
  assign sum      = tens_x10 + {3'b000, digito};
  assign digit_ok = (digito <= 4'd9);
  assign cnt_inc  = cnt_q + 1'b1;

  // Next-state and output decode; priority is clear, digit, enter, then timeout.
  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    cnt_d    = cnt_q;
    numero_d = numero_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      tens_d  = 4'd0;
      cnt_d   = '0;
    end else if (digito_valid) begin
      if (!digit_ok) begin
        err_d   = 1'b1;
        state_d = IDLE;
        tens_d  = 4'd0;
        cnt_d   = '0;
      end else if (state_q == IDLE) begin
        tens_d  = digito;
        state_d = WAIT_UNITS;
        cnt_d   = '0;
      end else begin
        numero_d = WIDTH'(sum);
        valid_d  = 1'b1;
        state_d  = IDLE;
        tens_d   = 4'd0;
        cnt_d    = '0;
      end
    end else if (enter && (state_q == WAIT_UNITS)) begin
      numero_d = WIDTH'(tens_q);
      valid_d  = 1'b1;
      state_d  = IDLE;
      tens_d   = 4'd0;
      cnt_d    = '0;
    end else if ((state_q == WAIT_UNITS) && (TIMEOUT_CYCLES > 0)) begin
      // The counter stops at the limit: reaching it aborts the entry instead of wrapping.
      if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
        err_d   = 1'b1;
        state_d = IDLE;
        tens_d  = 4'd0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // State, held digit, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tens_q   <= 4'd0;
      cnt_q    <= '0;
      numero_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      cnt_q    <= cnt_d;
      numero_q <= numero_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign numero       = numero_q;
  assign numero_valid = valid_q;
  assign error        = err_q;
  assign busy         = (state_q == WAIT_UNITS);

endmodule

// File: tb/tb_num_joiner.sv
// tb/tb_num_joiner.sv - scoreboard bench for num_joiner
module tb_num_joiner;

  logic       clk;
  logic       rst_n;
  logic [3:0] digito;
  logic       digito_valid;
  logic       enter;
  logic       clear;
  logic [7:0] numero;
  logic       numero_valid;
  logic       busy;
  logic       error;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit is_err;
    int val;
  } exp_t;

  exp_t sb[$];

  num_joiner #(.WIDTH(8), .TIMEOUT_CYCLES(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digito       (digito),
    .digito_valid (digito_valid),
    .enter        (enter),
    .clear        (clear),
    .numero       (numero),
    .numero_valid (numero_valid),
    .busy         (busy),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit is_err, input int val);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    sb.push_back(e);
  endtask

  // Present inputs for exactly one rising edge, then return to idle.
  task automatic cycle(input int d, input bit dv, input bit en, input bit clr);
    digito       = 4'(d);
    digito_valid = dv;
    enter        = en;
    clear        = clr;
    @(posedge clk);
    #1;
    digito       = 4'd0;
    digito_valid = 1'b0;
    enter        = 1'b0;
    clear        = 1'b0;
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (numero_valid && error) begin
        check("valid_and_error_together", 1, 0);
      end
      if (numero_valid || error) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {30'd0, numero_valid, error}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_kind_is_error", int'(error), int'(e.is_err));
          check("numero_value", int'(numero), e.val);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    digito       = 4'd0;
    digito_valid = 1'b0;
    enter        = 1'b0;
    clear        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_numero", int'(numero), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(numero_valid), 0);
    check("reset_error", int'(error), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4 then 5 -> 45
    cycle(4, 1, 0, 0);
    check("busy_after_tens", int'(busy), 1);
    push(0, 45);
    cycle(5, 1, 0, 0);
    check("busy_after_units", int'(busy), 0);

    // 7, gap, enter -> 7; enter in IDLE does nothing
    cycle(7, 1, 0, 0);
    cycle(0, 0, 0, 0);
    push(0, 7);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("enter_idle_hold", int'(numero), 7);

    // 3 then invalid 12 -> error, numero held; then 9,9 -> 99
    cycle(3, 1, 0, 0);
    push(1, 7);
    cycle(12, 1, 0, 0);
    check("busy_after_invalid", int'(busy), 0);
    cycle(9, 1, 0, 0);
    push(0, 99);
    cycle(9, 1, 0, 0);

    // Timeout: tens 2, five idle cycles -> error on the fifth
    cycle(2, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    check("busy_before_timeout", int'(busy), 1);
    push(1, 99);
    cycle(0, 0, 0, 0);
    check("busy_after_timeout", int'(busy), 0);

    // Units after three idle cycles -> 28, no timeout
    cycle(2, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    push(0, 28);
    cycle(8, 1, 0, 0);

    // clear beats a simultaneous digit
    cycle(6, 1, 0, 0);
    cycle(1, 1, 0, 1);
    check("busy_after_clear", int'(busy), 0);
    check("numero_after_clear", int'(numero), 28);

    // digit beats a simultaneous enter
    cycle(6, 1, 0, 0);
    push(0, 61);
    cycle(1, 1, 1, 0);

    // All 100 pairs back to back
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        cycle(t, 1, 0, 0);
        push(0, 10 * t + u);
        cycle(u, 1, 0, 0);
      end
    end
    cycle(0, 0, 0, 0);

    // Reset while a tens digit is held
    cycle(5, 1, 0, 0);
    check("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_numero", int'(numero), 0);
    check("midreset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    check("postreset_busy", int'(busy), 0);

    // Entry works again after reset: 1,2 -> 12
    cycle(1, 1, 0, 0);
    push(0, 12);
    cycle(2, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
